shiftreg_universal: RTL

- Parametrised successor to the team's 3-bit serial-in shift register: WIDTH-bit universal register with hold, shift left/right, rotate left/right, parallel load and clear.
- Adds a multi-step burst command: one request shifts or rotates N positions on consecutive cycles, with a busy/done handshake.
- Used as the generic serialiser/deserialiser and bit-manipulation element in training-phase datapaths.

---
 rtl/shiftreg_universal.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/shiftreg_universal.sv
// shiftreg_universal
//   WIDTH-bit universal shift register: hold, shift left/right, rotate
//   left/right, parallel load and clear, plus a multi-step burst that
//   shifts/rotates N positions on consecutive cycles with busy/done.
//
//   Optional feature macro: SHIFTREG_PARITY_EN
//     defined   -> adds output 'parity' = registered ^q (same edge as q)
//     undefined -> no parity port
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   en     in   single-step enable (IDLE only)
//   op     in   [2:0] 000 HOLD,001 SHL,010 SHR,011 ROL,100 ROR,101 LOAD,110 CLEAR,111 HOLD
//   sin    in   serial in (LSB on SHL, MSB on SHR)
//   pdata  in   [WIDTH-1:0] parallel load data
//   start  in   burst request (IDLE only, wins over en)
//   cnt    in   [CW-1:0] burst length, saturated to WIDTH
//   q      out  [WIDTH-1:0] register contents
//   sout   out  bit shifted/rotated out by the most recent step
//   busy   out  high while bursting
//   done   out  one-cycle pulse at burst end
//   parity out  (SHIFTREG_PARITY_EN only) ^q
module shiftreg_universal #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                CW        = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic             sin,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef SHIFTREG_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_SHL   = 3'b001;
  localparam logic [2:0] OP_SHR   = 3'b010;
  localparam logic [2:0] OP_ROL   = 3'b011;
  localparam logic [2:0] OP_ROR   = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [1:0]       state, state_d;
  logic [2:0]       cap_op;
  logic [CW-1:0]    rem, rem_d;
  logic [2:0]       step_op;
  logic             do_step;
  logic             op_is_move;
  logic [CW-1:0]    cnt_sat;
  logic [WIDTH-1:0] q_d;
  logic             sout_d;

  assign busy = (state == S_BUSY);
  assign done = (state == S_DONE);

  // During a burst the captured op drives the datapath; live op is ignored.
  assign step_op    = (state == S_BUSY) ? cap_op : op;
  assign do_step    = (state == S_BUSY) || (state == S_IDLE && !start && en);
  assign op_is_move = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
  assign cnt_sat    = (cnt > CNT_MAX) ? CNT_MAX : cnt;

  // Datapath: next q / sout for the selected step.
  always_comb begin
    q_d    = q;
    sout_d = sout;
    if (do_step) begin
      unique case (step_op)
        OP_SHL:   begin q_d = {q[WIDTH-2:0], sin};      sout_d = q[WIDTH-1]; end
        OP_SHR:   begin q_d = {sin, q[WIDTH-1:1]};      sout_d = q[0];       end
        OP_ROL:   begin q_d = {q[WIDTH-2:0], q[WIDTH-1]}; sout_d = q[WIDTH-1]; end
        OP_ROR:   begin q_d = {q[0], q[WIDTH-1:1]};     sout_d = q[0];       end
        OP_LOAD:  q_d = pdata;
        OP_CLEAR: q_d = RESET_VAL;
        default:  q_d = q;
      endcase
    end
  end

  // Control FSM.
  always_comb begin
    state_d = state;
    rem_d   = rem;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (op_is_move && cnt != '0) begin
            state_d = S_BUSY;
            rem_d   = cnt_sat;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_BUSY: begin
        rem_d = rem - 1'b1;
        if (rem == CW'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      rem    <= '0;
      cap_op <= OP_HOLD;
      q      <= RESET_VAL;
      sout   <= 1'b0;
    end else begin
      state <= state_d;
      rem   <= rem_d;
      q     <= q_d;
      sout  <= sout_d;
      if (state == S_IDLE && start) cap_op <= op;
    end
  end

`ifdef SHIFTREG_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) parity <= ^RESET_VAL;
    else       parity <= ^q_d;
  end
`endif

endmodule
